// File: rtl/network_sched.sv
// network_sched: round-robin scheduler sharing one network datapath among N_REQ requesters
// Ports: clk/rst (sync, active high); req, req_d (N_REQ x 120-bit cube states) in;
// ack, resp_valid (one-hot pulses), resp_q, resp_err, busy, fault out;
// net_load, net_d drive the network; net_valid, net_q return its result.
// Optional watchdog: define NETWORK_SCHED_WATCHDOG_EN to enable the TIMEOUT fault path.
module network_sched #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*120-1:0] req_d,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [3:0]         resp_q,
    output logic               resp_err,
    output logic               busy,
    output logic               fault,
    output logic               net_load,
    output logic [119:0]       net_d,
    input  logic               net_valid,
    input  logic [3:0]         net_q
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN, FAULT} state_t;

    state_t        state;
    logic [IW-1:0] rr, gidx, win;

    // The lowest offset from rr wins, so scan offsets high to low and let the last hit stand.
    always_comb begin
        win = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req[(int'(rr) + k) % N_REQ]) win = IW'((int'(rr) + k) % N_REQ);
    end

    assign busy = (state != IDLE);

`ifdef NETWORK_SCHED_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt;
    logic          err_q, fault_q;
    assign resp_err = err_q;
    assign fault    = fault_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign resp_err = 1'b0;
    assign fault    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr         <= '0;
            gidx       <= '0;
            net_d      <= '0;
            resp_q     <= '0;
            ack        <= '0;
            resp_valid <= '0;
            net_load   <= 1'b0;
`ifdef NETWORK_SCHED_WATCHDOG_EN
            cnt        <= '0;
            err_q      <= 1'b0;
            fault_q    <= 1'b0;
`endif
        end else begin
            ack        <= '0;
            resp_valid <= '0;
            net_load   <= 1'b0;
`ifdef NETWORK_SCHED_WATCHDOG_EN
            err_q      <= 1'b0;
`endif
            case (state)
                IDLE: if (|req) begin
                    gidx     <= win;
                    net_d    <= req_d[int'(win)*120 +: 120];
                    ack      <= N_REQ'(1) << win;
                    net_load <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    rr    <= (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
                    state <= WAIT;
`ifdef NETWORK_SCHED_WATCHDOG_EN
                    cnt   <= '0;
`endif
                end
                WAIT: if (net_valid) begin
                    resp_q     <= net_q;
                    resp_valid <= N_REQ'(1) << gidx;
                    state      <= RESP;
                end
`ifdef NETWORK_SCHED_WATCHDOG_EN
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    resp_q     <= '0;
                    resp_valid <= N_REQ'(1) << gidx;
                    err_q      <= 1'b1;
                    fault_q    <= 1'b1;
                    state      <= FAULT;
                end else cnt <= cnt + 1'b1;
`endif
                RESP:  state <= DRAIN;
                // Wait out a lingering net_valid so it cannot complete the next job.
                DRAIN: if (!net_valid) state <= IDLE;
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_network_sched.sv
// tb_network_sched: directed table-driven bench for network_sched
module tb_network_sched;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*120-1:0] req_d;
    logic [N-1:0]   ack, resp_valid;
    logic [3:0]     resp_q;
    logic           resp_err, busy, fault, net_load;
    logic [119:0]   net_d;
    logic           net_valid;
    logic [3:0]     net_q;

    always #5 clk = ~clk;

    network_sched #(.N_REQ(N), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_d(req_d), .ack(ack),
        .resp_valid(resp_valid), .resp_q(resp_q), .resp_err(resp_err),
        .busy(busy), .fault(fault), .net_load(net_load), .net_d(net_d),
        .net_valid(net_valid), .net_q(net_q)
    );

    typedef struct {
        bit         do_rst;
        logic [3:0] rq;
        logic [3:0] next_rq;
        int         lat;
        logic [3:0] q;
        int         hold;
        logic [3:0] exp_ack;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [119:0] slice(input int i);
        return {4{30'(32'h0ABC_0000 + i * 32'h111)}};
    endfunction

    function automatic int idx(input logic [3:0] oh);
        for (int i = 0; i < N; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_ctrl"}, {ack, resp_valid, net_load, busy, fault, resp_err, resp_q}, '0);
        chk({tag, "_net_d"}, net_d, '0);
    endtask

    task automatic do_reset;
        rst = 1'b1; req = '0; net_valid = 1'b0; net_q = '0;
        tick; tick;
        chk_reset("reset");
        rst = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin tick; n++; end while (ack == '0 && n < 50);
    endtask

    task automatic do_job(input vec_t v);
        int n;
        int extra;
        req = v.rq;
        wait_ack(n);
        chk("ack", ack, v.exp_ack);
        chk("net_load", net_load, 1);
        chk("net_d", net_d, slice(idx(v.exp_ack)));
        req = v.next_rq;
        tick;
        chk("ack_pulse", ack, 0);
        chk("busy_wait", busy, 1);
        extra = 0;
        for (int i = 0; i < v.lat; i++) begin
            tick;
            if (resp_valid != '0 || ack != '0 || net_load) extra++;
        end
        net_valid = 1'b1; net_q = v.q;
        tick;
        chk("resp_valid", resp_valid, v.exp_ack);
        chk("resp_q", resp_q, v.q);
        chk("resp_err", resp_err, 0);
        for (int i = 0; i < v.hold; i++) begin
            tick;
            if (resp_valid != '0 || ack != '0 || net_load) extra++;
        end
        chk("no_extra_pulses", extra, 0);
        net_valid = 1'b0; net_q = '0;
    endtask

    vec_t vt[11];

    initial begin
        int n;
        int extra;
        vt[0]  = '{1'b1, 4'b0100, 4'b0000, 20, 4'd7,  0, 4'b0100};
        vt[1]  = '{1'b1, 4'b1111, 4'b1111,  3, 4'd1,  2, 4'b0001};
        vt[2]  = '{1'b0, 4'b1111, 4'b1111,  1, 4'd2,  0, 4'b0010};
        vt[3]  = '{1'b0, 4'b1111, 4'b1111,  5, 4'd3,  1, 4'b0100};
        vt[4]  = '{1'b0, 4'b1111, 4'b1111,  2, 4'd4,  0, 4'b1000};
        vt[5]  = '{1'b0, 4'b1111, 4'b0000,  4, 4'd15, 0, 4'b0001};
        vt[6]  = '{1'b0, 4'b0001, 4'b0010,  6, 4'd9,  5, 4'b0001};
        vt[7]  = '{1'b0, 4'b0010, 4'b0000,  2, 4'd10, 0, 4'b0010};
        vt[8]  = '{1'b0, 4'b1001, 4'b1001,  3, 4'd11, 0, 4'b1000};
        vt[9]  = '{1'b0, 4'b1001, 4'b0000,  1, 4'd12, 0, 4'b0001};
        vt[10] = '{1'b0, 4'b0101, 4'b0000,  0, 4'd5,  0, 4'b0100};
        for (int i = 0; i < N; i++) req_d[i*120 +: 120] = slice(i);
        rst = 1'b1; req = '0; net_valid = 1'b0; net_q = '0;
        for (int i = 0; i < 11; i++) begin
            if (vt[i].do_rst) do_reset;
            do_job(vt[i]);
        end

        // Network never answers: watchdog fault, or indefinite WAIT without it.
        req = 4'b0100;
        wait_ack(n);
        chk("wd_ack", ack, 4'b0100);
        req = '0;
        tick;
`ifdef NETWORK_SCHED_WATCHDOG_EN
        n = 0;
        while (resp_valid == '0 && n < 40) begin tick; n++; end
        chk("wd_latency", n, 16);
        chk("wd_resp_valid", resp_valid, 4'b0100);
        chk("wd_resp_err", resp_err, 1);
        chk("wd_resp_q", resp_q, 0);
        chk("wd_fault", fault, 1);
        tick;
        chk("wd_single_pulse", {resp_valid, resp_err}, 0);
        req = 4'b1111;
        extra = 0;
        repeat (10) begin tick; if (ack != '0 || net_load) extra++; end
        chk("wd_ignores_req", extra, 0);
        chk("wd_fault_sticky", fault, 1);
        chk("wd_busy", busy, 1);
`else
        n = 0;
        repeat (40) begin tick; if (resp_valid != '0) n++; end
        chk("nowd_no_resp", n, 0);
        chk("nowd_fault", fault, 0);
        chk("nowd_busy", busy, 1);
        chk("nowd_resp_err", resp_err, 0);
`endif
        do_reset;

        // Reset three cycles into a job abandons it and restarts round-robin at 0.
        req = 4'b0010;
        wait_ack(n);
        chk("rw_ack", ack, 4'b0010);
        req = '0;
        tick; tick; tick;
        chk("rw_in_wait", busy, 1);
        rst = 1'b1; net_valid = 1'b1; net_q = 4'd3;
        tick; tick;
        chk_reset("rw_reset");
        rst = 1'b0; net_valid = 1'b0; net_q = '0;
        extra = 0;
        repeat (3) begin tick; if (resp_valid != '0) extra++; end
        chk("rw_no_resp", extra, 0);
        req = 4'b1111;
        wait_ack(n);
        chk("rw_next_grant", ack, 4'b0001);
        do_reset;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/network_sched.md
# network_sched

Round-robin scheduler that shares the single `network` inference datapath among several requesters. A requester is typically a cube solver instance that needs a move evaluation. The scheduler accepts one 120-bit cube state at a time, issues a one-cycle start to `network`, waits for its result, and returns the 4-bit move to the granted requester. It sits between the requester fabric and `network`, and is the only driver of `network`'s `load` and `d`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 4096: maximum WAIT cycles before a fault. Used only when the watchdog is compiled in.

Ports:
- `clk`  in  1  system clock; everything on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `req`  in  N_REQ  per-requester request level.
- `req_d`  in  N_REQ*120  cube state; slice i is `req_d[i*120 +: 120]`.
- `ack`  out  N_REQ  one-hot, one-cycle pulse: slice i captured.
- `resp_valid`  out  N_REQ  one-hot, one-cycle pulse: result for requester i.
- `resp_q`  out  4  move index; valid with `resp_valid`.
- `resp_err`  out  1  qualifies `resp_valid`: timed-out job.
- `busy`  out  1  high in every state except IDLE.
- `fault`  out  1  sticky watchdog fault.
- `net_load`  out  1  start pulse to `network.load`.
- `net_d`  out  120  to `network.d`; registered and held stable.
- `net_valid`  in  1  from `network.valid`; level, high while the network is finished.
- `net_q`  in  4  from `network.q`.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP, DRAIN, FAULT.
- **IDLE**
  - If `req` is nonzero, pick a winner by round-robin, searching upward from pointer `rr` with wrap.
  - Latch the winner index into `gidx` and its `req_d` slice into `net_d`, then go to ISSUE.
- **ISSUE** (one cycle)
  - `ack[gidx]=1`, `net_load=1`.
  - Set `rr = gidx+1` mod N_REQ.
  - Go to WAIT.
- **WAIT**
  - On `net_valid=1`, capture `net_q` into the `resp_q` register and go to RESP.
- **RESP** (one cycle)
  - `resp_valid[gidx]=1`, `resp_err=0`.
  - Go to DRAIN.
- **DRAIN**
  - Stay until `net_valid=0`, then go to IDLE. This prevents a stale `net_valid` from completing the next job.
- **Ignored inputs:**
  - `net_valid` in IDLE or ISSUE.
  - `req` in any state other than IDLE.
- **Requester rules:**
  - Hold `req` and the data slice stable until `ack`.
  - Deassert `req` in the cycle after `ack` unless another job is wanted.
  - A request dropped before grant is simply not granted.
- **Fairness:**
  - Each requester with `req` held continuously is granted within N_REQ jobs.
  - Requester i never receives two consecutive grants while any other `req` is high.
- **Reset values:**
  - State IDLE, `rr=0`, `gidx=0`.
  - `net_d=0`, `resp_q=0`, `fault=0`.
  - All pulses low.
  - Reset mid-job abandons the job; no `resp_valid` is issued for it.

## Timing
- `req` sampled high in IDLE at cycle t: `ack` and `net_load` at t+1, WAIT from t+2.
- `net_valid` first high at cycle v: `resp_valid` at v+1, with `resp_q` equal to `net_q` sampled at v.
- Back-to-back: the next IDLE is the cycle after `net_valid` is seen low in DRAIN. The minimum gap between `net_load` pulses is therefore job latency + 3.
- `net_d` is unchanged from ISSUE until the next IDLE grant.

## Configuration
- **`NETWORK_SCHED_WATCHDOG_EN` defined:**
  - A $clog2(TIMEOUT)-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 with `net_valid=0`, emit `resp_valid[gidx]=1` with `resp_err=1` and `resp_q=0` the next cycle, then enter FAULT.
  - FAULT holds `fault=1` and `busy=1`, grants nothing, and is left only by `rst`.
- **Undefined:**
  - No counter; WAIT waits indefinitely.
  - FAULT is unreachable, and `fault` and `resp_err` are tied to 0.

## Test plan
- **Single request:** `req=4'b0100`, network model returns `q=4'd7` after 20 cycles. Expect `ack=4'b0100` once, one `net_load` pulse, then `resp_valid=4'b0100` with `resp_q=7` exactly one cycle after `net_valid` rises.
- **All four requesting from reset:** expect grant order 0,1,2,3,0, each job with `net_d` equal to that requester's slice.
- **Stale valid:** model holds `net_valid` high for 5 cycles after completion while `req[1]` is already pending. Expect no second `resp_valid`, and `ack[1]` only after `net_valid` falls.
- **Reset in WAIT:** assert `rst` 3 cycles after `net_load`. Expect all outputs at reset values, no `resp_valid`, and next grant to requester 0.
- **Watchdog (macro on, TIMEOUT=16):** network never responds. Expect `resp_valid[gidx]` with `resp_err=1` and `resp_q=0` 16 cycles after WAIT entry, `fault=1` stuck, and further `req` ignored until `rst`.
- **Macro off:** the same stimulus leaves the block in WAIT indefinitely with `fault=0`.
